// File: rtl/mem_data_interface_pkg.sv
// -----------------------------------------------------------------------------
// mem_data_interface_pkg
//   Shared types and defaults for the memory-side datapath stage.
//   - default widths / timeout
//   - mem_state_t : access sequencer state (IDLE / ACCESS)
//   - cnt_width() : width of the timeout counter for a given TIMEOUT
// -----------------------------------------------------------------------------
package mem_data_interface_pkg;

    localparam int DATA_W_DEF  = 32;
    localparam int ADDR_W_DEF  = 9;
    localparam int TIMEOUT_DEF = 16;

    typedef enum logic {
        IDLE   = 1'b0,
        ACCESS = 1'b1
    } mem_state_t;

    // Counter must be able to hold the value TIMEOUT itself.
    function automatic int cnt_width(input int timeout);
        return $clog2(timeout + 1);
    endfunction

    localparam int CNT_W_DEF = $clog2(TIMEOUT_DEF + 1);

endpackage

// File: rtl/mem_data_interface_if.sv
// -----------------------------------------------------------------------------
// mem_data_interface_if
//   Word-access bus between the datapath stage (master) and the RAM (slave).
//   Signals: mem_addr, mem_wdata, mem_req, mem_we (master -> RAM),
//            mem_rdata, mem_ack (RAM -> master).
//
//   Handshake: the master raises mem_req with mem_addr/mem_we/mem_wdata stable
//   and holds all of them until it samples mem_ack high on a rising edge. The
//   RAM answers with a single-cycle mem_ack; for reads mem_rdata is valid in
//   that same cycle. mem_req drops on the edge that samples mem_ack. The master
//   may withdraw mem_req without an ack (timeout); a late ack is then ignored.
// -----------------------------------------------------------------------------
interface mem_data_interface_if
    import mem_data_interface_pkg::*;
#(
    parameter int DATA_W = DATA_W_DEF,
    parameter int ADDR_W = ADDR_W_DEF
) ();

    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_wdata;
    logic              mem_req;
    logic              mem_we;
    logic [DATA_W-1:0] mem_rdata;
    logic              mem_ack;

    modport master (
        output mem_addr,
        output mem_wdata,
        output mem_req,
        output mem_we,
        input  mem_rdata,
        input  mem_ack
    );

    modport slave (
        input  mem_addr,
        input  mem_wdata,
        input  mem_req,
        input  mem_we,
        output mem_rdata,
        output mem_ack
    );

endinterface

// File: rtl/mem_data_interface_reg_en.sv
// -----------------------------------------------------------------------------
// mem_data_interface_reg_en
//   W-bit register with load enable and asynchronous active-low clear.
//   Ports: clk, clr_n (async clear to 0), en (load), d (data in), q (data out).
// -----------------------------------------------------------------------------
module mem_data_interface_reg_en #(
    parameter int W = 32
) (
    input  logic         clk,
    input  logic         clr_n,
    input  logic         en,
    input  logic [W-1:0] d,
    output logic [W-1:0] q
);

    logic [W-1:0] data_q;
    logic [W-1:0] data_d;

    always_comb begin
        data_d = data_q;
        if (en) begin
            data_d = d;
        end
    end

    always_ff @(posedge clk or negedge clr_n) begin
        if (!clr_n) begin
            data_q <= '0;
        end else begin
            data_q <= data_d;
        end
    end

    assign q = data_q;

endmodule

// File: rtl/mem_data_interface.sv
// -----------------------------------------------------------------------------
// mem_data_interface
//   Memory-side datapath stage. Holds MAR and MDR, loads them from the internal
//   bus while idle, and runs single word reads/writes to the RAM over the
//   req/ack bus with a cycle timeout.
//   Ports:
//     clk, clr_n          clock, asynchronous active-low reset
//     bus_in, MARin, MDRin  bus value and MAR/MDR load enables (idle only)
//     rd_start, wr_start  start a read (mem[MAR] -> MDR) / write (MDR -> mem[MAR])
//     mdr_out             MDR contents to the bus multiplexer
//     busy, done, err     access in progress / success pulse / sticky timeout
//     state_dbg           current sequencer state
//     mem                 master side of the RAM bus
// -----------------------------------------------------------------------------
module mem_data_interface
    import mem_data_interface_pkg::*;
#(
    parameter int DATA_W  = DATA_W_DEF,
    parameter int ADDR_W  = ADDR_W_DEF,
    parameter int TIMEOUT = TIMEOUT_DEF
) (
    input  logic              clk,
    input  logic              clr_n,
    input  logic [DATA_W-1:0] bus_in,
    input  logic              MARin,
    input  logic              MDRin,
    input  logic              rd_start,
    input  logic              wr_start,
    output logic [DATA_W-1:0] mdr_out,
    output logic              busy,
    output logic              done,
    output logic              err,
    output mem_state_t        state_dbg,
    mem_data_interface_if.master mem
);

    localparam int CNT_W = cnt_width(TIMEOUT);

    mem_state_t        state_q, state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic              we_q, we_d;
    logic              done_q, done_d;
    logic              err_q, err_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [DATA_W-1:0] wdata_q, wdata_d;

    logic [DATA_W-1:0] mar_q;
    logic [DATA_W-1:0] mdr_q;
    logic [DATA_W-1:0] mdr_din;
    logic              mar_en;
    logic              mdr_en;
    logic              timeout_hit;
    logic              mar_unused;

    // Last permitted ACCESS cycle: counter has seen TIMEOUT-1 ack-less edges.
    assign timeout_hit = (cnt_q == CNT_W'(TIMEOUT - 1));

    // ---------------------------------------------------------------- state reg
    always_ff @(posedge clk or negedge clr_n) begin
        if (!clr_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // -------------------------------------------------------------- next state
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: begin
                if (rd_start || wr_start) begin
                    state_d = ACCESS;
                end
            end
            ACCESS: begin
                if (mem.mem_ack || timeout_hit) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // ----------------------------------------------------------------- outputs
    always_comb begin
        cnt_d   = cnt_q;
        we_d    = we_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        done_d  = 1'b0;
        err_d   = err_q;
        mar_en  = 1'b0;
        mdr_en  = 1'b0;
        mdr_din = bus_in;
        case (state_q)
            IDLE: begin
                mar_en = MARin;
                mdr_en = MDRin;
                if (rd_start || wr_start) begin
                    // Address/data snapshot the current MAR/MDR, so a load on
                    // the same edge only affects later accesses. Read wins.
                    cnt_d   = '0;
                    we_d    = ~rd_start;
                    addr_d  = mar_q[ADDR_W-1:0];
                    wdata_d = mdr_q;
                    err_d   = 1'b0;
                end
            end
            ACCESS: begin
                cnt_d = cnt_q + CNT_W'(1);
                if (mem.mem_ack) begin
                    done_d = 1'b1;
                    if (!we_q) begin
                        mdr_en  = 1'b1;
                        mdr_din = mem.mem_rdata;
                    end
                end else if (timeout_hit) begin
                    err_d = 1'b1;
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge clr_n) begin
        if (!clr_n) begin
            cnt_q   <= '0;
            we_q    <= 1'b0;
            addr_q  <= '0;
            wdata_q <= '0;
            done_q  <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            cnt_q   <= cnt_d;
            we_q    <= we_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            done_q  <= done_d;
            err_q   <= err_d;
        end
    end

    // ----------------------------------------------------------- MAR / MDR
    mem_data_interface_reg_en #(.W(DATA_W)) u_mar (
        .clk   (clk),
        .clr_n (clr_n),
        .en    (mar_en),
        .d     (bus_in),
        .q     (mar_q)
    );

    mem_data_interface_reg_en #(.W(DATA_W)) u_mdr (
        .clk   (clk),
        .clr_n (clr_n),
        .en    (mdr_en),
        .d     (mdr_din),
        .q     (mdr_q)
    );

    // Upper MAR bits are held but never reach the RAM address.
    assign mar_unused = ^mar_q[DATA_W-1:ADDR_W];

    // mem_req follows the state flop directly so reset withdraws it at once.
    assign mem.mem_req   = (state_q == ACCESS);
    assign mem.mem_we    = we_q;
    assign mem.mem_addr  = addr_q;
    assign mem.mem_wdata = wdata_q;

    assign busy      = (state_q != IDLE);
    assign done      = done_q;
    assign err       = err_q;
    assign mdr_out   = mdr_q;
    assign state_dbg = state_q;

endmodule

// File: tb/tb_mem_data_interface.sv
module tb_mem_data_interface;
    import mem_data_interface_pkg::*;

    localparam int DW = 32;
    localparam int AW = 9;
    localparam int TO = 16;
    localparam int EXP_W = 1 + 1 + AW + DW;   // {timeout, we, addr, mdr}

    // ------------------------------------------------------ clock / reset
    logic clk = 1'b0;
    logic clr_n = 1'b0;
    always #5 clk = ~clk;

    logic [DW-1:0] bus_in = '0;
    logic          MARin = 1'b0;
    logic          MDRin = 1'b0;
    logic          rd_start = 1'b0;
    logic          wr_start = 1'b0;
    logic [DW-1:0] mdr_out;
    logic          busy, done, err;
    mem_state_t    state_dbg;

    mem_data_interface_if #(.DATA_W(DW), .ADDR_W(AW)) mif ();

    mem_data_interface #(.DATA_W(DW), .ADDR_W(AW), .TIMEOUT(TO)) dut (
        .clk       (clk),
        .clr_n     (clr_n),
        .bus_in    (bus_in),
        .MARin     (MARin),
        .MDRin     (MDRin),
        .rd_start  (rd_start),
        .wr_start  (wr_start),
        .mdr_out   (mdr_out),
        .busy      (busy),
        .done      (done),
        .err       (err),
        .state_dbg (state_dbg),
        .mem       (mif)
    );

    // ------------------------------------------------------ reference model
    logic [DW-1:0]    m_mar = '0;
    logic [DW-1:0]    m_mdr = '0;
    logic [DW-1:0]    m_ram [0:(1<<AW)-1];
    logic [DW-1:0]    tb_ram[0:(1<<AW)-1];
    logic [EXP_W-1:0] exp_q[$];
    int               ack_delay = 0;   // 0 = RAM never answers
    int               n_vec = 0;
    int               n_fail = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // ------------------------------------------------------ RAM responder
    initial begin
        int d;
        int guard;
        mif.mem_ack   = 1'b0;
        mif.mem_rdata = '0;
        forever begin
            @(negedge clk);
            if (clr_n && mif.mem_req) begin
                d = ack_delay;
                if (d >= 1) begin
                    for (int i = 1; i < d && mif.mem_req; i++) @(negedge clk);
                    if (mif.mem_req && clr_n) begin
                        if (mif.mem_we) tb_ram[mif.mem_addr] = mif.mem_wdata;
                        mif.mem_rdata = tb_ram[mif.mem_addr];
                        mif.mem_ack   = 1'b1;
                        @(negedge clk);
                        mif.mem_ack   = 1'b0;
                        mif.mem_rdata = $urandom;
                    end
                end
                guard = 0;
                while (mif.mem_req && clr_n && guard < 64) begin
                    @(negedge clk);
                    guard++;
                end
            end
        end
    end

    // ------------------------------------------------------ monitor
    logic             busy_prev = 1'b0;
    logic             done_prev = 1'b0;
    logic [EXP_W-1:0] e;

    initial begin
        forever begin
            @(negedge clk);
            if (!clr_n) begin
                busy_prev = 1'b0;
                done_prev = 1'b0;
            end else begin
                if (done_prev) check("done_width", done, 1'b0);
                if (busy_prev && !busy) begin
                    if (exp_q.size() == 0) begin
                        check("unexpected_completion", 1'b1, 1'b0);
                    end else begin
                        e = exp_q.pop_front();
                        check("done",     done,        !e[EXP_W-1]);
                        check("err",      err,         e[EXP_W-1]);
                        check("mem_we",   mif.mem_we,  e[EXP_W-2]);
                        check("mem_addr", mif.mem_addr, e[AW+DW-1:DW]);
                        check("mdr_out",  mdr_out,     e[DW-1:0]);
                        check("req_drop", mif.mem_req, 1'b0);
                    end
                end
                busy_prev = busy;
                done_prev = done;
            end
        end
    end

    // ------------------------------------------------------ driver tasks
    // All tasks start and end at a negedge with the DUT idle.
    task automatic load(input bit ld_mar, input bit ld_mdr, input logic [DW-1:0] bus);
        MARin = ld_mar; MDRin = ld_mdr; bus_in = bus;
        if (ld_mar) m_mar = bus;
        if (ld_mdr) m_mdr = bus;
        @(negedge clk);
        MARin = 1'b0; MDRin = 1'b0;
    endtask

    task automatic access(input bit rd, input bit wr, input int delay,
                          input bit ld_mar, input bit ld_mdr,
                          input logic [DW-1:0] bus, input bit poke);
        logic [AW-1:0] addr;
        logic          we;
        logic [DW-1:0] old_mdr;
        bit            to;
        int            n;
        addr    = m_mar[AW-1:0];
        we      = !rd;
        old_mdr = m_mdr;
        if (ld_mar) m_mar = bus;
        if (ld_mdr) m_mdr = bus;
        to = (delay == 0) || (delay > TO);
        if (!to) begin
            if (we) m_ram[addr] = old_mdr;
            else    m_mdr = m_ram[addr];
        end
        exp_q.push_back({to, we, addr, m_mdr});
        ack_delay = delay;
        rd_start = rd; wr_start = wr; MARin = ld_mar; MDRin = ld_mdr; bus_in = bus;
        @(negedge clk);
        rd_start = 1'b0; wr_start = 1'b0; MARin = 1'b0; MDRin = 1'b0;
        check("err_clear", err, 1'b0);
        check("busy_set", busy, 1'b1);
        check("req_set", mif.mem_req, 1'b1);
        if (poke) begin
            // Loads and starts while busy must be ignored.
            MARin = 1'b1; MDRin = 1'b1; bus_in = $urandom; rd_start = 1'b1; wr_start = 1'b1;
            @(negedge clk);
            MARin = 1'b0; MDRin = 1'b0; rd_start = 1'b0; wr_start = 1'b0;
        end
        n = 0;
        while (busy && n < TO + 4) begin
            @(negedge clk);
            n++;
        end
        if (busy) check("busy_stuck", busy, 1'b0);
    endtask

    task automatic idle_ack();
        mif.mem_ack = 1'b1; mif.mem_rdata = $urandom;
        @(negedge clk);
        mif.mem_ack = 1'b0;
        check("idle_ack_mdr", mdr_out, m_mdr);
        check("idle_ack_done", done, 1'b0);
        check("idle_ack_busy", busy, 1'b0);
    endtask

    // ------------------------------------------------------ watchdog
    initial begin
        #1000000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    // ------------------------------------------------------ main sequence
    initial begin
        int r, dly, diff;
        for (int i = 0; i < (1 << AW); i++) begin
            m_ram[i]  = $urandom;
            tb_ram[i] = m_ram[i];
        end

        // Reset with an MDR load pending
        MDRin = 1'b1; bus_in = 32'hDEADBEEF; clr_n = 1'b0;
        repeat (3) @(negedge clk);
        check("rst_mdr", mdr_out, 32'h0);
        check("rst_busy", busy, 1'b0);
        check("rst_done", done, 1'b0);
        check("rst_err", err, 1'b0);
        check("rst_req", mif.mem_req, 1'b0);
        check("rst_we", mif.mem_we, 1'b0);
        check("rst_addr", mif.mem_addr, 9'h0);
        check("rst_state", state_dbg, IDLE);
        clr_n = 1'b1;
        @(negedge clk);
        m_mdr = 32'hDEADBEEF;
        check("post_rst_mdr_load", mdr_out, m_mdr);
        MDRin = 1'b0;
        @(negedge clk);

        // Directed read, ack 3 cycles later
        m_ram[9'h012] = 32'hCAFEF00D; tb_ram[9'h012] = 32'hCAFEF00D;
        load(1'b1, 1'b0, 32'h00000012);
        access(1'b1, 1'b0, 3, 1'b0, 1'b0, '0, 1'b0);
        check("read_data", mdr_out, 32'hCAFEF00D);

        // Directed write to top address, ack next cycle
        load(1'b1, 1'b0, 32'h000001FF);
        load(1'b0, 1'b1, 32'h0000ABCD);
        access(1'b0, 1'b1, 1, 1'b0, 1'b0, '0, 1'b0);
        check("write_ram", tb_ram[9'h1FF], 32'h0000ABCD);

        // Timeout, then a write clears err
        access(1'b1, 1'b0, 0, 1'b0, 1'b0, '0, 1'b0);
        access(1'b0, 1'b1, 2, 1'b0, 1'b0, '0, 1'b0);
        // Ack arriving just after the timeout is ignored
        access(1'b1, 1'b0, TO + 1, 1'b0, 1'b0, '0, 1'b0);
        // Ack on the last permitted cycle still succeeds
        access(1'b1, 1'b0, TO, 1'b0, 1'b0, '0, 1'b0);

        // Read and write together: read only
        access(1'b1, 1'b1, 2, 1'b0, 1'b0, '0, 1'b0);
        // Loads/starts while busy
        access(1'b1, 1'b0, 4, 1'b0, 1'b0, '0, 1'b1);
        access(1'b0, 1'b1, 1, 1'b0, 1'b0, '0, 1'b1);
        // Load on the same edge as start uses the old MAR/MDR
        access(1'b0, 1'b1, 2, 1'b1, 1'b1, 32'h00000055, 1'b0);
        access(1'b1, 1'b0, 1, 1'b0, 1'b0, '0, 1'b0);
        // Upper MAR bits are dropped
        load(1'b1, 1'b0, 32'hFFFFFE12);
        access(1'b1, 1'b0, 2, 1'b0, 1'b0, '0, 1'b0);
        idle_ack();

        // Randomized accesses
        for (int k = 0; k < 80; k++) begin
            r = $urandom_range(0, 9);
            dly = (r == 0) ? 0 : (r == 1) ? $urandom_range(TO + 1, TO + 4) : $urandom_range(1, TO);
            if ($urandom_range(0, 3) == 0) load($urandom_range(0, 1), $urandom_range(0, 1), $urandom);
            if ($urandom_range(0, 7) == 0) idle_ack();
            r = $urandom_range(0, 7);
            access(r == 0 || r[0], r == 0 || !r[0], dly,
                   $urandom_range(0, 3) == 0, $urandom_range(0, 3) == 0, $urandom,
                   $urandom_range(0, 3) == 0);
        end

        // Reset in the middle of an access
        ack_delay = 0;
        rd_start = 1'b1;
        @(negedge clk);
        rd_start = 1'b0;
        repeat (3) @(negedge clk);
        #2 clr_n = 1'b0;
        #1;
        check("midrst_req", mif.mem_req, 1'b0);
        check("midrst_busy", busy, 1'b0);
        check("midrst_state", state_dbg, IDLE);
        m_mar = '0; m_mdr = '0;
        @(negedge clk);
        clr_n = 1'b1;
        @(negedge clk);
        check("post_midrst_state", state_dbg, IDLE);
        access(1'b1, 1'b0, 1, 1'b0, 1'b0, '0, 1'b0);

        repeat (4) @(negedge clk);
        check("exp_q_empty", exp_q.size(), 0);
        diff = 0;
        for (int i = 0; i < (1 << AW); i++) if (tb_ram[i] !== m_ram[i]) diff++;
        check("ram_contents", diff, 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
        $finish;
    end

endmodule
